// File: rtl/axi4_lite_master.sv
// axi4_lite_master
// Single-outstanding AXI4-Lite initiator. A local command (write or read) is
// accepted while idle, turned into exactly one AXI transaction, and reported
// back as a one-cycle rsp_valid pulse carrying the response code and read data.
//
// Ports:
//   axi_clk, axi_rst          bus clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_wr selects write (1) / read (0)
//   cmd_addr/wdata/wstrb      command payload, captured on accept
//   rsp_valid/rsp_rdata/resp  completion pulse, read data (0 for writes), B/R resp
//   busy                      transaction in flight (= !cmd_ready)
//   stall                     sticky watchdog flag, cleared by the next accept
//   m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite initiator channels
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | cmd_ready high, waiting for a command
// S_WR_REQ | AW and/or W still outstanding, each tracked by its own VALID
// S_WR_RESP| both write handshakes done, m_bready high, waiting for B
// S_RD_REQ | m_arvalid high, waiting for AR handshake
// S_RD_DATA| m_rready high, waiting for R
// S_DONE   | rsp_valid pulse cycle; cmd_ready returns on the next cycle
module axi4_lite_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic                    stall,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] wd_cnt;

  // Protection is fixed: unprivileged, secure, data access.
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      stall     <= 1'b0;
      wd_cnt    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      // Watchdog: down-counter loaded on accept; reaching zero while busy
      // sets stall. A load of zero (TIMEOUT_CYCLES = 0) never fires.
      if (busy && wd_cnt != 32'd0) begin
        wd_cnt <= wd_cnt - 32'd1;
        if (wd_cnt == 32'd1) stall <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            stall     <= 1'b0;
            wd_cnt    <= 32'(TIMEOUT_CYCLES);
            if (cmd_wr) begin
              m_awaddr  <= cmd_addr;
              m_wdata   <= cmd_wdata;
              m_wstrb   <= cmd_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= S_WR_REQ;
            end else begin
              m_araddr  <= cmd_addr;
              m_arvalid <= 1'b1;
              state     <= S_RD_REQ;
            end
          end
        end

        S_WR_REQ: begin
          // Each VALID clears on its own handshake; the phase ends once
          // both are either already low or handshaking this cycle.
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
            state    <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= m_bresp;
            rsp_rdata <= '0;
            state     <= S_DONE;
          end
        end

        S_RD_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
module tb_axi4_lite_master;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          axi_clk = 1'b0;
  logic          axi_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy, stall;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic          m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
  logic [DW-1:0] m_rdata = '0;

  always #5 axi_clk = ~axi_clk;

  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .stall(stall),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // slave configuration
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_rsp = 2'b00, r_rsp = 2'b00;

  // slave state and bus monitor records
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic [31:0] smem [2048];
  logic [31:0] rmem [2048];
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [SW-1:0] last_wstrb = '0;

  // previous-cycle view for protocol checks
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [SW-1:0] p_wstrb = '0;

  always @(posedge axi_clk) begin
    if (axi_rst) begin
      got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr) begin
        chk("aw_hold", m_awvalid, 1'b1);
        chk("aw_stable", m_awaddr, p_awaddr);
      end
      if (p_awv && p_awr) chk("aw_drop", m_awvalid, 1'b0);
      if (p_wv && !p_wr) begin
        chk("w_hold", m_wvalid, 1'b1);
        chk("w_stable", {m_wstrb, m_wdata}, {p_wstrb, p_wdata});
      end
      if (p_wv && p_wr) chk("w_drop", m_wvalid, 1'b0);
      if (p_arv && !p_arr) begin
        chk("ar_hold", m_arvalid, 1'b1);
        chk("ar_stable", m_araddr, p_araddr);
      end
      if (m_bvalid && m_bready) begin n_b++; b_pend = 0; end
      if (m_awvalid && m_awready) begin
        n_aw++; got_aw = 1; s_awaddr = m_awaddr; last_awaddr = m_awaddr;
      end
      if (m_wvalid && m_wready) begin
        n_w++; got_w = 1; s_wdata = m_wdata; s_wstrb = m_wstrb;
        last_wdata = m_wdata; last_wstrb = m_wstrb;
      end
      if (got_aw && got_w) begin
        smem[s_awaddr[12:2]] = merge(smem[s_awaddr[12:2]], s_wdata, s_wstrb);
        got_aw = 0; got_w = 0; b_pend = 1; b_wait = 0;
      end
      if (m_rvalid && m_rready) begin n_r++; r_pend = 0; end
      if (m_arvalid && m_arready) begin
        n_ar++; r_pend = 1; r_wait = 0; s_araddr = m_araddr; last_araddr = m_araddr;
      end
      p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
      p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
      p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
    end
  end

  always @(negedge axi_clk) begin
    if (axi_rst) begin
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (m_awvalid) begin
        if (aw_wait >= aw_dly) m_awready = 1; else begin aw_wait++; m_awready = 0; end
      end else begin m_awready = 0; aw_wait = 0; end
      if (m_wvalid) begin
        if (w_wait >= w_dly) m_wready = 1; else begin w_wait++; m_wready = 0; end
      end else begin m_wready = 0; w_wait = 0; end
      if (m_arvalid) begin
        if (ar_wait >= ar_dly) m_arready = 1; else begin ar_wait++; m_arready = 0; end
      end else begin m_arready = 0; ar_wait = 0; end
      if (b_pend) begin
        if (b_wait >= b_dly) begin m_bvalid = 1; m_bresp = b_rsp; end else b_wait++;
      end else m_bvalid = 0;
      if (r_pend) begin
        if (r_wait >= r_dly) begin
          m_rvalid = 1; m_rresp = r_rsp; m_rdata = smem[s_araddr[12:2]];
        end else r_wait++;
      end else m_rvalid = 0;
    end
  end

  // One command end to end, entered and left on a falling edge.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st);
    int t, lat, exp_lat, aw0, w0, b0, ar0, r0;
    logic [DW-1:0] exp_rd;
    logic [1:0] exp_resp;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge axi_clk); t++; end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    @(posedge axi_clk);
    @(negedge axi_clk);
    cmd_valid = 0; cmd_wr = ~wr;
    cmd_addr = {$urandom, $urandom}; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    lat = 1;
    chk("busy_after_accept", {busy, cmd_ready, stall}, 3'b100);
    while (!rsp_valid && lat < 200) begin @(negedge axi_clk); lat++; end
    chk("rsp_seen", rsp_valid, 1'b1);
    if (wr) begin
      exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      exp_rd = '0; exp_resp = b_rsp;
      rmem[addr[12:2]] = merge(rmem[addr[12:2]], wd, st);
    end else begin
      exp_lat = 3 + ar_dly + r_dly;
      exp_rd = rmem[addr[12:2]]; exp_resp = r_rsp;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_resp", rsp_resp, exp_resp);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("ready_during_rsp", {cmd_ready, busy}, 2'b01);
    chk("prot", {m_awprot, m_arprot}, 6'd0);
    if (wr) begin
      chk("n_aw", n_aw - aw0, 1); chk("n_w", n_w - w0, 1); chk("n_b", n_b - b0, 1);
      chk("n_ar_wr", n_ar - ar0, 0);
      chk("awaddr", last_awaddr, addr);
      chk("wdata", {last_wstrb, last_wdata}, {st, wd});
    end else begin
      chk("n_ar", n_ar - ar0, 1); chk("n_r", n_r - r0, 1); chk("n_aw_rd", n_aw - aw0, 0);
      chk("araddr", last_araddr, addr);
    end
    @(negedge axi_clk);
    chk("after_rsp", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    int nb, t, nrsp;
    logic [AW-1:0] a;
    for (int i = 0; i < 2048; i++) begin smem[i] = '0; rmem[i] = '0; end
    repeat (3) @(negedge axi_clk);
    chk("rst_outputs", {cmd_ready, rsp_valid, busy, stall, m_awvalid, m_wvalid,
                        m_bready, m_arvalid, m_rready}, 9'b100000000);
    chk("rst_payload", {m_awaddr, m_araddr} | {m_wdata, m_wstrb, rsp_rdata, rsp_resp}, '0);
    axi_rst = 0;
    @(negedge axi_clk);

    // zero-wait write then read-back
    run_cmd(1, 64'h10, 32'h00AB_CDEF, 4'hF);
    run_cmd(0, 64'h10, '0, '0);

    // AW delayed, W immediate
    aw_dly = 5;
    run_cmd(1, 64'h24, 32'h1234_5678, 4'h5);
    aw_dly = 0;

    // SLVERR write, then slow read data
    b_rsp = 2'b10;
    run_cmd(1, 64'h28, 32'hCAFE_F00D, 4'hF);
    b_rsp = 2'b00; r_dly = 10;
    run_cmd(0, 64'h28, '0, '0);
    r_dly = 0;

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      a = {$urandom, $urandom};
      a[12:2] = 11'($urandom_range(0, 15));
      a[1:0] = 2'b00;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_rsp = 2'($urandom); r_rsp = 2'($urandom);
      run_cmd(k < 4 ? 1'b1 : 1'($urandom), a, $urandom, 4'($urandom));
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; b_rsp = 0; r_rsp = 0;

    // watchdog: AR never accepted until released
    ar_dly = 1000;
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 64'h24;
    @(posedge axi_clk);
    @(negedge axi_clk);
    cmd_valid = 0;
    nb = 0; t = 0;
    while (!stall && t < 100) begin
      if (busy) nb++;
      t++;
      @(negedge axi_clk);
    end
    chk("stall_busy_cycles", nb, TO);
    chk("stall_arvalid", {stall, m_arvalid}, 2'b11);
    repeat (5) @(negedge axi_clk);
    chk("stall_sticky", {stall, m_arvalid, busy}, 3'b111);
    ar_dly = 0;
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge axi_clk); t++; end
    chk("stall_rsp", rsp_valid, 1'b1);
    chk("stall_rdata", rsp_rdata, rmem[10'h9]);
    @(negedge axi_clk);
    chk("stall_kept_idle", {stall, cmd_ready}, 2'b11);
    run_cmd(0, 64'h10, '0, '0);
    chk("stall_cleared", stall, 1'b0);

    // reset while waiting for B
    b_dly = 50;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 64'h30; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(posedge axi_clk);
    @(negedge axi_clk);
    cmd_valid = 0;
    t = 0;
    while (!m_bready && t < 20) begin @(negedge axi_clk); t++; end
    chk("reached_wr_resp", m_bready, 1'b1);
    rmem[12] = 32'h5555_AAAA;
    repeat (2) @(negedge axi_clk);
    axi_rst = 1;
    #1;
    chk("async_rst", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, busy},
        7'd0);
    chk("async_rst_ready", cmd_ready, 1'b1);
    @(negedge axi_clk);
    axi_rst = 0;
    b_dly = 0;
    nrsp = 0;
    repeat (10) begin @(negedge axi_clk); if (rsp_valid) nrsp++; end
    chk("no_rsp_after_rst", nrsp, 0);
    chk("idle_after_rst", {cmd_ready, busy, stall}, 3'b100);
    run_cmd(0, 64'h30, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
